// File: rtl/rx_data_sampler.sv
// rx_data_sampler: oversampling front end of the UART receiver.
// Runs the per-bit edge counter and the frame bit counter. Majority-votes three
// mid-bit samples of RX_IN into sampled_bit. sample_done strobes during the cycle
// whose closing edge loads the new sampled_bit.
// Optional build macro: RX_SYNC_EN inserts a two-flop synchronizer on RX_IN.
// The synchronizer resets to 1 and delays sampling by two cycles; the counters are unaffected.
module rx_data_sampler #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  cnt_en,
   input  logic                  data_sample_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  sampled_bit,
   output logic                  sample_done
);

   localparam logic [PRESCALE_W-1:0] P8      = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] P16     = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] P32     = PRESCALE_W'(32);
   localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] TWO     = PRESCALE_W'(2);
   localparam logic [BIT_CNT_W-1:0]  BIT_MAX = '1;

   logic                  rx_s;
   logic [PRESCALE_W-1:0] prescale_legal;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] last_edge;
   logic [PRESCALE_W-1:0] pt_s0;
   logic [PRESCALE_W-1:0] pt_s1;
   logic [PRESCALE_W-1:0] pt_s2;
   logic [PRESCALE_W-1:0] pt_upd;
   logic                  sample_active;
   logic                  upd_hit;
   logic                  s0;
   logic                  s1;
   logic                  s2;
   logic                  vote_valid;

`ifdef RX_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchronizer on the asynchronous serial line; idles high.
   always_ff @(posedge CLK) begin
      if (RST) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], RX_IN};
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = RX_IN;
`endif

   // Map the requested ratio onto a supported one; anything unsupported runs at 8.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      prescale_legal = P8;
      if (prescale == P16 || prescale == P32) prescale_legal = prescale;
   end

   // Ratio is captured while idle and frozen for the whole frame.
   always_ff @(posedge CLK) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (RST)          prescale_q <= P8;
      else if (!cnt_en) prescale_q <= prescale_legal;
   end

   // Sample and update points derived from the latched ratio; all land below P-1.
   always_comb begin
      half      = prescale_q >> 1;
      last_edge = prescale_q - ONE;
      pt_s0     = half - ONE;
      pt_s1     = half;
      pt_s2     = half + ONE;
      pt_upd    = half + TWO;
   end

   assign sample_active = cnt_en & data_sample_en;
   assign upd_hit       = sample_active & vote_valid & (edge_cnt == pt_upd);
   // A reset edge discards the vote, so the strobe must not announce it.
   assign sample_done   = upd_hit & ~RST;

   // Edge counter wraps each bit period; bit counter counts periods and saturates.
   always_ff @(posedge CLK) begin
      if (RST || !cnt_en) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (edge_cnt == last_edge) begin
         edge_cnt <= '0;
         if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end else begin
         edge_cnt <= edge_cnt + ONE;
      end
   end

   // Capture three mid-bit samples, then vote; losing the enable abandons the vote.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s0          <= 1'b0;
         s1          <= 1'b0;
         s2          <= 1'b0;
         vote_valid  <= 1'b0;
         sampled_bit <= 1'b1;
      end else if (!sample_active) begin
         s0         <= 1'b0;
         s1         <= 1'b0;
         s2         <= 1'b0;
         vote_valid <= 1'b0;
      end else begin
         if (edge_cnt == pt_s0) begin
            s0         <= rx_s;
            vote_valid <= 1'b1;
         end
         if (edge_cnt == pt_s1) s1 <= rx_s;
         if (edge_cnt == pt_s2) s2 <= rx_s;
         if (upd_hit) begin
            sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
            vote_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed testbench for rx_data_sampler: reset, counting, majority vote,
// prescale latching, saturation, vote abort, reset mid-frame, input path delay.
module tb_rx_data_sampler;

   localparam int PW = 6;
   localparam int BW = 4;

   logic          clk;
   logic          rst;
   logic          rx_in;
   logic [PW-1:0] prescale;
   logic          cnt_en;
   logic          data_sample_en;
   logic [PW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          sampled_bit;
   logic          sample_done;

   int checks   = 0;
   int failures = 0;

   rx_data_sampler #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
      .CLK            (clk),
      .RST            (rst),
      .RX_IN          (rx_in),
      .prescale       (prescale),
      .cnt_en         (cnt_en),
      .data_sample_en (data_sample_en),
      .edge_cnt       (edge_cnt),
      .bit_cnt        (bit_cnt),
      .sampled_bit    (sampled_bit),
      .sample_done    (sample_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; inputs may change and outputs are stable afterwards.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One bit period of p cycles starting at edge_cnt = 0. mask[k] is RX_IN while
   // edge_cnt = k. data_sample_en drops from abort_at on (-1: never).
   task automatic run_bit(input int p, input logic [31:0] mask, input int abort_at,
                          input logic exp_bit, input string name);
      int  h;
      logic exp_done;
      h = p / 2;
      cnt_en = 1'b1;
      for (int pos = 0; pos < p; pos++) begin
         data_sample_en = (abort_at < 0) || (pos < abort_at);
         rx_in = mask[pos];
         #1;
         checks++;
         if (edge_cnt !== 6'(pos)) begin
            failures++;
            $display("FAIL %s edge_cnt got=%0d exp=%0d", name, edge_cnt, pos);
         end
         exp_done = (pos == h + 2) && data_sample_en;
         checks++;
         if (sample_done !== exp_done) begin
            failures++;
            $display("FAIL %s sample_done pos=%0d got=%b exp=%b", name, pos, sample_done, exp_done);
         end
         if (pos == h + 3) begin
            checks++;
            if (sampled_bit !== exp_bit) begin
               failures++;
               $display("FAIL %s sampled_bit got=%b exp=%b", name, sampled_bit, exp_bit);
            end
         end
         step();
      end
      checks++;
      if (edge_cnt !== 6'd0) begin
         failures++;
         $display("FAIL %s wrap edge_cnt got=%0d exp=0", name, edge_cnt);
      end
   endtask

   // Drop cnt_en for one cycle so the next frame relatches prescale.
   task automatic idle_cycle(input logic [PW-1:0] ps);
      cnt_en   = 1'b0;
      prescale = ps;
      rx_in    = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; cnt_en = 1'b1; rx_in = 1'b0; data_sample_en = 1'b1; prescale = 6'd8;
      step();
      step();
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_done !== 1'b0) begin
         failures++;
         $display("FAIL reset got edge=%0d bit=%0d sb=%b sd=%b exp 0 0 1 0",
                  edge_cnt, bit_cnt, sampled_bit, sample_done);
      end
      rst = 1'b0;
      idle_cycle(6'd8);
   endtask

   task automatic test_counting();
      idle_cycle(6'd8);
      cnt_en = 1'b1; data_sample_en = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         step();
         checks++;
         if (edge_cnt !== 6'(i % 8) || bit_cnt !== 4'(i / 8)) begin
            failures++;
            $display("FAIL count cycle=%0d got edge=%0d bit=%0d exp edge=%0d bit=%0d",
                     i, edge_cnt, bit_cnt, i % 8, i / 8);
         end
      end
      cnt_en = 1'b0;
      step();
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
         failures++;
         $display("FAIL count_clear got edge=%0d bit=%0d exp 0 0", edge_cnt, bit_cnt);
      end
   endtask

   task automatic test_majority();
      idle_cycle(6'd16);
      run_bit(16, 32'h0000_0100, -1, 1'b0, "maj_one_high");
      run_bit(16, 32'h0000_0180, -1, 1'b1, "maj_two_high");
      run_bit(16, 32'h0000_0000, -1, 1'b0, "maj_all_low");
      run_bit(16, 32'hFFFF_FEFF, -1, 1'b1, "glitch_low");
   endtask

   task automatic test_prescale();
      idle_cycle(6'd8);
      run_bit(8, 32'h0000_0000, -1, 1'b0, "p8");
      prescale = 6'd32;
      run_bit(8, 32'hFFFF_FFFF, -1, 1'b1, "p32_midframe");
      idle_cycle(6'd32);
      run_bit(32, 32'hFFFE_7FFF, -1, 1'b0, "p32_points");
      idle_cycle(6'd12);
      run_bit(8, 32'hFFFF_FFFF, -1, 1'b1, "p12_as_8");
   endtask

   task automatic test_abort();
      run_bit(8, 32'h0000_0000, 4, 1'b1, "abort");
   endtask

   task automatic test_saturation();
      idle_cycle(6'd8);
      cnt_en = 1'b1; data_sample_en = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (i == 127) begin
            checks++;
            if (bit_cnt !== 4'd15) begin
               failures++;
               $display("FAIL sat_127 bit_cnt got=%0d exp=15", bit_cnt);
            end
         end
      end
      checks++;
      if (bit_cnt !== 4'd15 || edge_cnt !== 6'd0) begin
         failures++;
         $display("FAIL sat_200 got bit=%0d edge=%0d exp bit=15 edge=0", bit_cnt, edge_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      idle_cycle(6'd8);
      cnt_en = 1'b1; data_sample_en = 1'b1; rx_in = 1'b0;
      repeat (6) step();
      rst = 1'b1;
      #1;
      checks++;
      if (sample_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid sample_done got=%b exp=0", sample_done);
      end
      step();
      checks++;
      if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || sampled_bit !== 1'b1 || sample_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid state got edge=%0d bit=%0d sb=%b sd=%b exp 0 0 1 0",
                  edge_cnt, bit_cnt, sampled_bit, sample_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_input_path();
      logic exp_bit;
`ifdef RX_SYNC_EN
      exp_bit = 1'b0;
`else
      exp_bit = 1'b1;
`endif
      idle_cycle(6'd8);
      run_bit(8, 32'hFFFF_FFF1, -1, exp_bit, "input_path");
   endtask

   initial begin
      test_reset();
      test_counting();
      test_majority();
      test_prescale();
      test_abort();
      test_saturation();
      test_reset_midframe();
      test_input_path();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
